// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter and instruction fetch stage
//
// Holds the PC and fetches one 16-bit instruction per request from
// instruction memory. The downstream control FSM advances the PC
// sequentially, by a signed 8-bit displacement, or to an absolute target.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   PCEn                  advance strobe, honoured only while holding an instruction
//   PCState[1:0]          next-PC select: 00/11 PC+1, 01 PC+sext(Imm), 10 JumpTarget
//   Imm[7:0]              signed branch displacement
//   JumpTarget[15:0]      absolute jump address
//   MemAddr[15:0], MemRd  instruction memory request
//   MemRdata[15:0]        instruction memory read data, valid with MemReady
//   MemReady              memory completes the read this cycle
//   Instr[15:0]           captured instruction word
//   InstrValid            Instr holds the instruction at PC
//   PC[15:0]              current program counter
//   LinkAddr[15:0]        PC+1 for link-register writes
//   Busy                  fetch or retry in progress
//   FetchErr              sticky fetch-timeout flag

module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PCEn,
    input  logic [1:0]  PCState,
    input  logic [7:0]  Imm,
    input  logic [15:0] JumpTarget,
    output logic [15:0] MemAddr,
    output logic        MemRd,
    input  logic [15:0] MemRdata,
    input  logic        MemReady,
    output logic [15:0] Instr,
    output logic        InstrValid,
    output logic [15:0] PC,
    output logic [15:0] LinkAddr,
    output logic        Busy,
    output logic        FetchErr
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_RETRY = 2'd2
    } state_t;

    // Last wait count before a retry is forced; MAX_WAIT is at most 255.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] instr_nxt;
    logic        valid_nxt;
    logic        err_nxt;
    logic [15:0] next_pc;

    always_comb begin
        next_pc = PC + 16'd1;
        case (PCState)
            2'b01:   next_pc = PC + {{8{Imm[7]}}, Imm};
            2'b10:   next_pc = JumpTarget;
            default: next_pc = PC + 16'd1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_FETCH;
            PC         <= RESET_PC;
            Instr      <= 16'h0000;
            InstrValid <= 1'b0;
            FetchErr   <= 1'b0;
            wait_cnt   <= 8'd0;
        end else begin
            state      <= state_nxt;
            PC         <= pc_nxt;
            Instr      <= instr_nxt;
            InstrValid <= valid_nxt;
            FetchErr   <= err_nxt;
            wait_cnt   <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        instr_nxt = Instr;
        valid_nxt = InstrValid;
        err_nxt   = FetchErr;
        wait_nxt  = wait_cnt;
        case (state)
            S_FETCH: begin
                // A completion on the timeout cycle wins over the retry.
                if (MemReady) begin
                    instr_nxt = MemRdata;
                    valid_nxt = 1'b1;
                    wait_nxt  = 8'd0;
                    state_nxt = S_HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_nxt   = 1'b1;
                    wait_nxt  = 8'd0;
                    state_nxt = S_RETRY;
                end else begin
                    wait_nxt  = wait_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                // Instr keeps the old word until the next capture.
                if (PCEn) begin
                    pc_nxt    = next_pc;
                    valid_nxt = 1'b0;
                    state_nxt = S_FETCH;
                end
            end
            S_RETRY: state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Gated by Reset_n so the request drops the instant reset asserts.
    assign MemRd    = Reset_n & (state == S_FETCH);
    assign Busy     = Reset_n & ((state == S_FETCH) | (state == S_RETRY));
    assign MemAddr  = PC;
    assign LinkAddr = PC + 16'd1;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

    logic        Clk;
    logic        Reset_n;
    logic        PCEn;
    logic [1:0]  PCState;
    logic [7:0]  Imm;
    logic [15:0] JumpTarget;
    logic [15:0] MemAddr;
    logic        MemRd;
    logic [15:0] MemRdata;
    logic        MemReady;
    logic [15:0] Instr;
    logic        InstrValid;
    logic [15:0] PC;
    logic [15:0] LinkAddr;
    logic        Busy;
    logic        FetchErr;

    int checks = 0;
    int errors = 0;

    int lat = 0;
    int seen = 0;
    logic force_rdy = 1'b0;

    instr_fetch_unit #(.RESET_PC(16'h0000), .MAX_WAIT(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PCEn(PCEn), .PCState(PCState),
        .Imm(Imm), .JumpTarget(JumpTarget), .MemAddr(MemAddr), .MemRd(MemRd),
        .MemRdata(MemRdata), .MemReady(MemReady), .Instr(Instr),
        .InstrValid(InstrValid), .PC(PC), .LinkAddr(LinkAddr), .Busy(Busy),
        .FetchErr(FetchErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h5103;
        return (a * 16'h9E37) ^ 16'hC35A;
    endfunction

    // Memory: answers after 'lat' not-ready request cycles; force_rdy
    // asserts MemReady unconditionally.
    always @(negedge Clk) begin
        #2;
        if (force_rdy) begin
            MemReady = 1'b1;
            MemRdata = 16'hDEAD;
        end else if (MemRd) begin
            if (seen >= lat) begin
                MemReady = 1'b1;
                MemRdata = mem_word(MemAddr);
            end else begin
                MemReady = 1'b0;
            end
            seen++;
        end else begin
            MemReady = 1'b0;
            seen = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [1:0] ps, input logic [7:0] im, input logic [15:0] jt);
        PCEn = 1'b1;
        PCState = ps;
        Imm = im;
        JumpTarget = jt;
        @(negedge Clk);
        PCEn = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!InstrValid && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        checks++;
        if (!InstrValid) begin
            errors++;
            $display("FAIL wait_valid: got timeout after %0d cycles expected InstrValid", cyc);
        end
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [1:0] ps,
                                               input logic [7:0] im, input logic [15:0] jt);
        int d;
        if (ps == 2'b10) return jt;
        if (ps == 2'b01) begin
            d = (im > 8'd127) ? int'(im) - 256 : int'(im);
            return 16'((int'(pc) + d + 65536) % 65536);
        end
        return 16'((int'(pc) + 1) % 65536);
    endfunction

    typedef struct {
        logic [15:0] base;
        logic [1:0]  ps;
        logic [7:0]  imm;
        logic [15:0] jt;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [15:0] pc_m;
        logic [15:0] held;

        vecs[0] = '{16'hFFFF, 2'b00, 8'h00, 16'h0000, 16'h0000};
        vecs[1] = '{16'h0010, 2'b01, 8'hF0, 16'h0000, 16'h0000};
        vecs[2] = '{16'h0010, 2'b01, 8'h7F, 16'h0000, 16'h008F};
        vecs[3] = '{16'h0000, 2'b01, 8'hFF, 16'h0000, 16'hFFFF};
        vecs[4] = '{16'h1234, 2'b11, 8'h33, 16'hBEEF, 16'h1235};
        vecs[5] = '{16'h0000, 2'b10, 8'h12, 16'h1234, 16'h1234};
        vecs[6] = '{16'h8000, 2'b01, 8'h80, 16'h0000, 16'h7F80};
        vecs[7] = '{16'h7FF0, 2'b00, 8'hAA, 16'h5555, 16'h7FF1};

        PCEn = 1'b0; PCState = 2'b00; Imm = 8'h00; JumpTarget = 16'h0000;
        MemReady = 1'b0; MemRdata = 16'h0000;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_memrd", 32'(MemRd), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_pc", 32'(PC), 32'h0000);
        chk("rst_memaddr", 32'(MemAddr), 32'h0000);
        chk("rst_link", 32'(LinkAddr), 32'h0001);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", 32'(Instr), 32'h0000);
        chk("rst_err", 32'(FetchErr), 32'd0);

        // First fetch, zero-wait memory
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk("t1_memrd", 32'(MemRd), 32'd1);
        chk("t1_memaddr", 32'(MemAddr), 32'h0000);
        chk("t1_busy", 32'(Busy), 32'd1);
        @(negedge Clk);
        chk("t1_valid", 32'(InstrValid), 32'd1);
        chk("t1_instr", 32'(Instr), 32'h5103);
        chk("t1_pc", 32'(PC), 32'h0000);
        chk("t1_link", 32'(LinkAddr), 32'h0001);
        chk("t1_memrd_hold", 32'(MemRd), 32'd0);

        // Next-PC arithmetic table
        foreach (vecs[i]) begin
            pulse(2'b10, 8'h00, vecs[i].base);
            wait_valid(cyc);
            chk("tbl_base", 32'(PC), 32'(vecs[i].base));
            pulse(vecs[i].ps, vecs[i].imm, vecs[i].jt);
            chk("tbl_pc", 32'(PC), 32'(vecs[i].exp_pc));
            chk("tbl_valid_drop", 32'(InstrValid), 32'd0);
            wait_valid(cyc);
            chk("tbl_cycles", 32'(cyc), 32'd1);
            chk("tbl_instr", 32'(Instr), 32'(mem_word(vecs[i].exp_pc)));
        end

        // Jump, then a branch strobe during a 3-wait fetch is ignored
        lat = 3;
        pulse(2'b10, 8'h00, 16'h1234);
        @(negedge Clk);
        pulse(2'b01, 8'h05, 16'h0000);
        wait_valid(cyc);
        chk("t4_pc", 32'(PC), 32'h1234);
        chk("t4_instr", 32'(Instr), 32'(mem_word(16'h1234)));
        chk("t4_err", 32'(FetchErr), 32'd0);

        // Timeout with MAX_WAIT=4
        lat = 255;
        pulse(2'b00, 8'h00, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("t5_wait_memrd", 32'(MemRd), 32'd1);
            chk("t5_wait_err", 32'(FetchErr), 32'd0);
        end
        @(negedge Clk);
        chk("t5_retry_memrd", 32'(MemRd), 32'd0);
        chk("t5_retry_busy", 32'(Busy), 32'd1);
        chk("t5_err", 32'(FetchErr), 32'd1);
        @(negedge Clk);
        chk("t5_refetch_memrd", 32'(MemRd), 32'd1);
        chk("t5_refetch_addr", 32'(MemAddr), 32'h1235);
        lat = 0;
        @(negedge Clk);
        chk("t5_valid", 32'(InstrValid), 32'd1);
        chk("t5_instr", 32'(Instr), 32'(mem_word(16'h1235)));
        chk("t5_err_sticky", 32'(FetchErr), 32'd1);

        // Async reset mid-fetch
        lat = 255;
        pulse(2'b10, 8'h00, 16'h4321);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        chk("t6_memrd", 32'(MemRd), 32'd0);
        chk("t6_valid", 32'(InstrValid), 32'd0);
        chk("t6_err", 32'(FetchErr), 32'd0);
        chk("t6_pc", 32'(PC), 32'h0000);
        chk("t6_busy", 32'(Busy), 32'd0);
        force_rdy = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        force_rdy = 1'b0;
        chk("t6_rdy_valid", 32'(InstrValid), 32'd0);
        chk("t6_rdy_instr", 32'(Instr), 32'h0000);
        lat = 0;
        Reset_n = 1'b1;
        #1;
        chk("t6_rel_memrd", 32'(MemRd), 32'd1);
        chk("t6_rel_addr", 32'(MemAddr), 32'h0000);
        @(negedge Clk);
        chk("t6_rel_valid", 32'(InstrValid), 32'd1);
        chk("t6_rel_instr", 32'(Instr), 32'h5103);

        // Randomized traffic against the reference model
        pc_m = 16'h0000;
        for (int it = 0; it < 150; it++) begin
            logic [1:0]  ps;
            logic [7:0]  im;
            logic [15:0] jt;
            int idle;
            int junk_at;
            logic do_junk;
            idle = $urandom_range(0, 2);
            held = Instr;
            for (int k = 0; k < idle; k++) @(negedge Clk);
            chk("rnd_hold_instr", 32'(Instr), 32'(held));
            chk("rnd_hold_valid", 32'(InstrValid), 32'd1);
            ps = 2'($urandom_range(0, 3));
            im = 8'($urandom);
            jt = 16'($urandom);
            lat = $urandom_range(0, 3);
            pulse(ps, im, jt);
            pc_m = model_next(pc_m, ps, im, jt);
            do_junk = 1'($urandom_range(0, 1));
            junk_at = $urandom_range(0, lat);
            cyc = 0;
            while (!InstrValid && cyc < 20) begin
                if (do_junk && cyc == junk_at) begin
                    PCEn = 1'b1;
                    PCState = 2'($urandom);
                    Imm = 8'($urandom);
                    JumpTarget = 16'($urandom);
                end
                @(negedge Clk);
                PCEn = 1'b0;
                cyc++;
            end
            chk("rnd_cycles", 32'(cyc), 32'(lat + 1));
            chk("rnd_pc", 32'(PC), 32'(pc_m));
            chk("rnd_instr", 32'(Instr), 32'(mem_word(pc_m)));
            chk("rnd_link", 32'(LinkAddr), 32'(16'(pc_m + 16'd1)));
            chk("rnd_err", 32'(FetchErr), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Program-counter and instruction-fetch stage that sits directly upstream of the multi-cycle CPU control FSM. It holds the PC and fetches one 16-bit instruction per request from instruction memory over a ready handshake. It presents the instruction word on Instr with a valid flag. It consumes the FSM's PCEn/PCState outputs to choose the next PC: sequential, PC-relative branch by 8-bit displacement, or absolute jump to a register value.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; first fetch address.
MAX_WAIT, 15, FETCH cycles without MemReady before a retry is forced (legal range 2..255).

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset_n  input  1  asynchronous active-low reset
PCEn  input  1  advance strobe from FSM; sampled only in HOLD state
PCState  input  2  next-PC select: 00 PC+1, 01 PC+sext(Imm), 10 JumpTarget, 11 PC+1 (reserved)
Imm  input  8  signed branch displacement (two's complement)
JumpTarget  input  16  absolute jump address (Rtarget register value)
MemAddr  output  16  instruction memory address (equals PC)
MemRd  output  1  instruction memory read request
MemRdata  input  16  instruction memory read data, valid when MemReady=1
MemReady  input  1  memory completes the read this cycle
Instr  output  16  captured instruction word
InstrValid  output  1  Instr holds the instruction at PC
PC  output  16  current program counter
LinkAddr  output  16  PC+1 (mod 2^16) for link-register writes
Busy  output  1  fetch in progress (state FETCH or RETRY)
FetchErr  output  1  sticky: at least one fetch timeout since reset

Behaviour:
- Reset (async, Reset_n=0) forces the following values immediately, with no clock needed: state=FETCH, PC=RESET_PC, Instr=16'h0000, InstrValid=0, FetchErr=0, wait_cnt=0. During reset MemRd=0 (gated by Reset_n), MemAddr=RESET_PC, LinkAddr=RESET_PC+1, Busy=0.
- Outputs:
  - MemRd = Reset_n & (state==FETCH).
  - Busy = Reset_n & (state==FETCH | state==RETRY).
  - MemAddr=PC.
  - LinkAddr=PC+1.
- States: FETCH, HOLD, RETRY.
- FETCH, MemReady=1 at edge: Instr<=MemRdata, InstrValid<=1, wait_cnt<=0, ->HOLD. Zero-wait memory therefore gives InstrValid one edge after entering FETCH.
- FETCH, MemReady=0:
  - If wait_cnt==MAX_WAIT-1: FetchErr<=1, wait_cnt<=0, ->RETRY.
  - Otherwise wait_cnt<=wait_cnt+1.
  - MemReady=1 on the timeout cycle completes the fetch; no error is raised.
- RETRY: exactly one cycle with MemRd=0, then ->FETCH at the same PC. Retries repeat indefinitely.
- HOLD, PCEn=1 at edge:
  - PC<=next_pc, InstrValid<=0, ->FETCH.
  - Instr keeps its old value until the new capture.
- HOLD, PCEn=0: all state holds. Instr/InstrValid stable.
- PCEn in FETCH or RETRY is ignored; it is neither queued nor counted. The FSM must only pulse PCEn while InstrValid=1.
- next_pc arithmetic, all 16-bit modulo 2^16 (wrap, no saturation, no flag):
  - 00/11: PC+1.
  - 01: PC + {{8{Imm[7]}},Imm}.
  - 10: JumpTarget.
  - PCState, Imm and JumpTarget are sampled on the same edge as PCEn.
- Reset asserted mid-fetch: MemRd drops asynchronously. A MemReady arriving while Reset_n=0 is ignored. After release, fetch restarts at RESET_PC.
- Reset release: the first rising edge with Reset_n=1 is evaluated in FETCH.

Test Plan:
1. Reset with RESET_PC=0, memory zero-wait, mem[0]=16'h5103 -> MemRd=1, MemAddr=0 on first cycle; next edge InstrValid=1, Instr=16'h5103, PC=0, LinkAddr=1.
2. Sequential and wrap: PC=16'hFFFF in HOLD, PCEn=1, PCState=00 -> PC=16'h0000, InstrValid=0 for one cycle, then mem[0] captured.
3. Branch: PC=16'h0010, PCEn=1, PCState=01, Imm=8'hF0 (-16) -> PC=16'h0000. Imm=8'h7F -> PC=16'h008F. PC=16'h0000 with Imm=8'hFF -> PC=16'hFFFF.
4. Jump and ignore-while-busy: PCState=10, JumpTarget=16'h1234 -> PC=16'h1234. Pulse PCEn=1 (PCState=01, Imm=8'h05) during the resulting 3-cycle-wait fetch -> ignored, PC stays 16'h1234, captured Instr=mem[16'h1234].
5. Timeout with MAX_WAIT=4, MemReady held 0 -> 4 FETCH cycles, then FetchErr=1 and one RETRY cycle with MemRd=0, then FETCH at same MemAddr. MemReady=1 later -> Instr captured, FetchErr stays 1.
6. Async reset mid-fetch: Reset_n=0 between edges during a wait -> MemRd, InstrValid, FetchErr go 0 immediately and PC=RESET_PC. MemReady pulsed during reset has no effect. After release, fetch restarts at RESET_PC.
